// File: rtl/qr_seq_pkg.sv
// Shared state type, width defaults and helpers for the QR_Engine frame sequencer.
package qr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_LAST = 2'd2,
        DONE      = 2'd3
    } qr_seq_state_e;

    localparam int QR_DATA_W       = 48;
    localparam int QR_R_W          = 320;
    localparam int QR_Y_W          = 160;
    localparam int QR_WORDS_PER_RE = 20;
    localparam int QR_CNT_W        = 16;

    // Saturating increment so a runaway beat or mismatch count can never wrap back to a "good" value.
    function automatic logic [QR_CNT_W-1:0] sat_inc(input logic [QR_CNT_W-1:0] v);
        if (v == {QR_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + QR_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/qr_seq_checker.sv
// Golden-result comparator for the frame sequencer: exact {r,y} compare per result beat,
// saturating mismatch counter and sticky underflow flag. Built only with QR_SEQ_CHECK_EN.
module qr_seq_checker
    import qr_seq_pkg::*;
#(
    parameter int R_W = QR_R_W,
    parameter int Y_W = QR_Y_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_beat,
    input  logic [R_W-1:0]      i_eng_r,
    input  logic [Y_W-1:0]      i_eng_y,
    input  logic                i_gold_vld,
    input  logic [R_W-1:0]      i_gold_r,
    input  logic [Y_W-1:0]      i_gold_y,
    output logic                o_gold_rdy,
    output logic [QR_CNT_W-1:0] o_mis_cnt,
    output logic                o_gold_ufl
);

    logic [QR_CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic                gold_ufl_q, gold_ufl_d;
    logic                miscompare_s;

    assign o_gold_rdy   = i_beat;
    assign miscompare_s = i_beat & i_gold_vld & ({i_eng_r, i_eng_y} != {i_gold_r, i_gold_y});

    // Next-state for the mismatch counter and underflow flag.
    always_comb begin
        mis_cnt_d  = mis_cnt_q;
        gold_ufl_d = gold_ufl_q;
        if (i_clr) begin
            mis_cnt_d  = {QR_CNT_W{1'b0}};
            gold_ufl_d = 1'b0;
        end else begin
            if (miscompare_s) begin
                mis_cnt_d = sat_inc(mis_cnt_q);
            end else begin
                mis_cnt_d = mis_cnt_q;
            end
            if (i_beat & ~i_gold_vld) begin
                gold_ufl_d = 1'b1;
            end else begin
                gold_ufl_d = gold_ufl_q;
            end
        end
    end

    // Checker state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mis_cnt_q  <= {QR_CNT_W{1'b0}};
            gold_ufl_q <= 1'b0;
        end else begin
            mis_cnt_q  <= mis_cnt_d;
            gold_ufl_q <= gold_ufl_d;
        end
    end

    assign o_mis_cnt  = mis_cnt_q;
    assign o_gold_ufl = gold_ufl_q;

endmodule

// File: rtl/qr_frame_sequencer.sv
// Frame driver for QR_Engine: bursts source words in groups, waits for o_last_data, counts result
// beats and flags count errors / stalls. Defining QR_SEQ_CHECK_EN adds the golden-result checker.
module qr_frame_sequencer
    import qr_seq_pkg::*;
#(
    parameter int DATA_W        = QR_DATA_W,
    parameter int RE_PER_GRP    = 10,
    parameter int WORDS_PER_GRP = QR_WORDS_PER_RE * RE_PER_GRP,
    parameter int NUM_GRP       = 100,
    parameter int TIMEOUT       = 4096
`ifdef QR_SEQ_CHECK_EN
    ,
    parameter int R_W           = QR_R_W,
    parameter int Y_W           = QR_Y_W
`endif
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_src_vld,
    input  logic [DATA_W-1:0]            i_src_data,
    output logic                         o_src_rdy,
    output logic                         o_eng_trig,
    output logic [DATA_W-1:0]            o_eng_data,
    input  logic                         i_eng_rd_vld,
    input  logic                         i_eng_last,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(NUM_GRP+1)-1:0] o_grp_cnt,
    output logic                         o_beat_err,
    output logic                         o_timeout
`ifdef QR_SEQ_CHECK_EN
    ,
    input  logic [R_W-1:0]               i_eng_r,
    input  logic [Y_W-1:0]               i_eng_y,
    input  logic                         i_gold_vld,
    input  logic [R_W-1:0]               i_gold_r,
    input  logic [Y_W-1:0]               i_gold_y,
    output logic                         o_gold_rdy,
    output logic [QR_CNT_W-1:0]          o_mis_cnt,
    output logic                         o_gold_ufl
`endif
);

    localparam int WC_W = $clog2(WORDS_PER_GRP + 1);
    localparam int GC_W = $clog2(NUM_GRP + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    qr_seq_state_e       state_q, state_d;
    logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
    logic [QR_CNT_W-1:0] beat_cnt_q, beat_cnt_d, beat_total_s;
    logic [GC_W-1:0]     grp_cnt_q, grp_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                trig_q, trig_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                beat_err_q, beat_err_d;
    logic                timeout_q, timeout_d;
    logic                src_rdy_s, busy_s, done_s;
    logic                start_s, accept_s, last_word_s, close_s, grp_full_s, timeout_hit_s;

    assign start_s       = i_start & (state_q == IDLE);
    assign accept_s      = i_src_vld & src_rdy_s;
    assign last_word_s   = accept_s & (word_cnt_q == WC_W'(WORDS_PER_GRP - 1));
    // A close is honoured in SEND too, so an early or coincident last skips WAIT_LAST.
    assign close_s       = i_eng_last & ((state_q == SEND) | (state_q == WAIT_LAST));
    assign grp_full_s    = (grp_cnt_q == GC_W'(NUM_GRP - 1));
    assign timeout_hit_s = (state_q == WAIT_LAST) & ~i_eng_last & (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign beat_total_s  = (i_eng_rd_vld & (state_q != IDLE)) ? sat_inc(beat_cnt_q) : beat_cnt_q;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = SEND;
                else         state_d = IDLE;
            end
            SEND: begin
                if (close_s)          state_d = grp_full_s ? DONE : SEND;
                else if (last_word_s) state_d = WAIT_LAST;
                else                  state_d = SEND;
            end
            WAIT_LAST: begin
                if (close_s)            state_d = grp_full_s ? DONE : SEND;
                else if (timeout_hit_s) state_d = IDLE;
                else                    state_d = WAIT_LAST;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        src_rdy_s = 1'b0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        case (state_q)
            IDLE: begin
                src_rdy_s = 1'b0;
                busy_s    = 1'b0;
            end
            SEND: begin
                src_rdy_s = 1'b1;
                busy_s    = 1'b1;
            end
            WAIT_LAST: busy_s = 1'b1;
            DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                src_rdy_s = 1'b0;
                busy_s    = 1'b0;
                done_s    = 1'b0;
            end
        endcase
    end

    // Datapath next-state: engine word pipe, counters and sticky flags.
    always_comb begin
        word_cnt_d = word_cnt_q;
        beat_cnt_d = beat_total_s;
        grp_cnt_d  = grp_cnt_q;
        trig_d     = accept_s;
        data_d     = data_q;
        beat_err_d = beat_err_q;
        timeout_d  = timeout_q;
        if (accept_s) data_d = i_src_data;
        else          data_d = data_q;
        if (state_q == WAIT_LAST) to_cnt_d = to_cnt_q + TO_W'(1);
        else                      to_cnt_d = {TO_W{1'b0}};
        if (start_s) begin
            word_cnt_d = {WC_W{1'b0}};
            beat_cnt_d = {QR_CNT_W{1'b0}};
            grp_cnt_d  = {GC_W{1'b0}};
            beat_err_d = 1'b0;
            timeout_d  = 1'b0;
        end else if (close_s) begin
            word_cnt_d = {WC_W{1'b0}};
            beat_cnt_d = {QR_CNT_W{1'b0}};
            grp_cnt_d  = grp_cnt_q + GC_W'(1);
            if (beat_total_s != QR_CNT_W'(RE_PER_GRP)) beat_err_d = 1'b1;
            else                                       beat_err_d = beat_err_q;
        end else begin
            if (last_word_s)   word_cnt_d = {WC_W{1'b0}};
            else if (accept_s) word_cnt_d = word_cnt_q + WC_W'(1);
            else               word_cnt_d = word_cnt_q;
            if (timeout_hit_s) timeout_d = 1'b1;
            else               timeout_d = timeout_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_cnt_q <= {WC_W{1'b0}};
            beat_cnt_q <= {QR_CNT_W{1'b0}};
            grp_cnt_q  <= {GC_W{1'b0}};
            to_cnt_q   <= {TO_W{1'b0}};
            trig_q     <= 1'b0;
            data_q     <= {DATA_W{1'b0}};
            beat_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            to_cnt_q   <= to_cnt_d;
            trig_q     <= trig_d;
            data_q     <= data_d;
            beat_err_q <= beat_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_src_rdy  = src_rdy_s;
    assign o_busy     = busy_s;
    assign o_done     = done_s;
    assign o_eng_trig = trig_q;
    assign o_eng_data = data_q;
    assign o_grp_cnt  = grp_cnt_q;
    assign o_beat_err = beat_err_q;
    assign o_timeout  = timeout_q;

`ifdef QR_SEQ_CHECK_EN
    qr_seq_checker #(
        .R_W (R_W),
        .Y_W (Y_W)
    ) u_checker (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (start_s),
        .i_beat     (i_eng_rd_vld),
        .i_eng_r    (i_eng_r),
        .i_eng_y    (i_eng_y),
        .i_gold_vld (i_gold_vld),
        .i_gold_r   (i_gold_r),
        .i_gold_y   (i_gold_y),
        .o_gold_rdy (o_gold_rdy),
        .o_mis_cnt  (o_mis_cnt),
        .o_gold_ufl (o_gold_ufl)
    );
`endif

endmodule

// File: tb/tb_qr_frame_sequencer.sv
// Self-checking bench for qr_frame_sequencer (NUM_GRP=2, TIMEOUT=64); covers QR_SEQ_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_qr_frame_sequencer;
    import qr_seq_pkg::*;

    localparam int DATA_W   = 48;
    localparam int RPG      = 10;
    localparam int WPG      = 200;
    localparam int NGRP     = 2;
    localparam int TMO      = 64;
    localparam int GC_W     = $clog2(NGRP + 1);
    localparam int LAST_DLY = 12;

    logic              i_clk = 1'b0;
    logic              i_rst, i_start, i_src_vld, i_eng_rd_vld, i_eng_last;
    logic [DATA_W-1:0] i_src_data;
    logic              o_src_rdy, o_eng_trig, o_busy, o_done, o_beat_err, o_timeout;
    logic [DATA_W-1:0] o_eng_data;
    logic [GC_W-1:0]   o_grp_cnt;
`ifdef QR_SEQ_CHECK_EN
    logic [QR_R_W-1:0] i_eng_r, i_gold_r;
    logic [QR_Y_W-1:0] i_eng_y, i_gold_y;
    logic              i_gold_vld, o_gold_rdy, o_gold_ufl;
    logic [15:0]       o_mis_cnt;
    int                corrupt_beat = -1;
    int                ufl_beat     = -1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    // results of the latest run, filled by run()
    int r_trig, r_done, r_bad, r_hole, r_gaps, r_to_wait, r_hung;

    always #5 i_clk = ~i_clk;

    qr_frame_sequencer #(
        .DATA_W(DATA_W), .RE_PER_GRP(RPG), .WORDS_PER_GRP(WPG), .NUM_GRP(NGRP), .TIMEOUT(TMO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_src_vld(i_src_vld), .i_src_data(i_src_data), .o_src_rdy(o_src_rdy),
        .o_eng_trig(o_eng_trig), .o_eng_data(o_eng_data),
        .i_eng_rd_vld(i_eng_rd_vld), .i_eng_last(i_eng_last),
        .o_busy(o_busy), .o_done(o_done), .o_grp_cnt(o_grp_cnt),
        .o_beat_err(o_beat_err), .o_timeout(o_timeout)
`ifdef QR_SEQ_CHECK_EN
        , .i_eng_r(i_eng_r), .i_eng_y(i_eng_y), .i_gold_vld(i_gold_vld),
        .i_gold_r(i_gold_r), .i_gold_y(i_gold_y), .o_gold_rdy(o_gold_rdy),
        .o_mis_cnt(o_mis_cnt), .o_gold_ufl(o_gold_ufl)
`endif
    );

    task automatic idle_inputs();
        i_start      = 1'b0;
        i_src_vld    = 1'b0;
        i_src_data   = '0;
        i_eng_rd_vld = 1'b0;
        i_eng_last   = 1'b0;
`ifdef QR_SEQ_CHECK_EN
        i_eng_r = '0; i_eng_y = '0; i_gold_r = '0; i_gold_y = '0; i_gold_vld = 1'b0;
`endif
    endtask

    // vld_mode: 0 always, 1 drop every 3rd cycle, 2 random.
    // eng_mode: 0 last LAST_DLY cycles after the group's last trig word, 1 last with the last word's
    // acceptance, 2 never. The bench scoreboard is a queue of words handed to the source.
    task automatic run(input int vld_mode, input int eng_mode, input int nbeats);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] exp_w;
        logic [63:0]       rnd;
        int  grp_words = 0, acc_words = 0, countdown = 0, last_acc = -1, pend_low = 0, idx;
        bit  seen_trig = 1'b0, vld_prev = 1'b0, finished = 1'b0, acc;
`ifdef QR_SEQ_CHECK_EN
        int  beat_no = 0;
`endif
        r_trig = 0; r_done = 0; r_bad = 0; r_hole = 0; r_gaps = 0; r_to_wait = -1; r_hung = 0;
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (o_eng_trig) begin
                r_trig++;
                if (!vld_prev) r_hole++;
                if (exp_q.size() == 0) r_bad++;
                else begin
                    exp_w = exp_q.pop_front();
                    if (o_eng_data !== exp_w) r_bad++;
                end
                if (seen_trig) r_gaps += pend_low;
                pend_low  = 0;
                seen_trig = 1'b1;
                grp_words++;
                if (grp_words == WPG) begin
                    grp_words = 0;
                    if (eng_mode == 0) countdown = LAST_DLY + 1;
                end
            end else if (seen_trig) pend_low++;
            if (o_done) r_done++;
            if (o_timeout && r_to_wait < 0 && last_acc >= 0) r_to_wait = cyc - last_acc - 1;
            idle_inputs();
            if (!o_busy) finished = 1'b1;
            else begin
                case (vld_mode)
                    0:       i_src_vld = 1'b1;
                    1:       i_src_vld = (cyc % 3 != 2);
                    default: i_src_vld = ($urandom_range(3, 0) != 0);
                endcase
                rnd = {$urandom(), $urandom()};
                i_src_data = rnd[DATA_W-1:0];
                acc = i_src_vld && o_src_rdy;
                if (acc) begin
                    exp_q.push_back(i_src_data);
                    acc_words++;
                    if (acc_words % WPG == 0) last_acc = cyc;
                end
                if (eng_mode == 1 && acc) begin
                    idx = (acc_words - 1) % WPG;
                    i_eng_rd_vld = (idx >= WPG - nbeats);
                    i_eng_last   = (idx == WPG - 1);
                end else if (eng_mode == 0 && countdown > 0) begin
                    i_eng_rd_vld = (countdown <= nbeats);
                    i_eng_last   = (countdown == 1);
                    countdown--;
                end
`ifdef QR_SEQ_CHECK_EN
                if (i_eng_rd_vld) begin
                    beat_no++;
                    for (int k = 0; k < QR_R_W / 32; k++) i_eng_r[k*32 +: 32] = $urandom();
                    for (int k = 0; k < QR_Y_W / 32; k++) i_eng_y[k*32 +: 32] = $urandom();
                    i_gold_r   = i_eng_r;
                    i_gold_y   = i_eng_y;
                    i_gold_vld = (beat_no != ufl_beat);
                    if (beat_no == corrupt_beat) i_gold_r[5] = ~i_gold_r[5];
                end
`endif
                vld_prev = i_src_vld;
            end
            @(negedge i_clk);
        end
        if (!finished) r_hung = 1;
        r_bad += exp_q.size();
        idle_inputs();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if ({o_src_rdy, o_eng_trig, o_busy, o_done, o_beat_err, o_timeout} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {o_src_rdy, o_eng_trig, o_busy, o_done, o_beat_err, o_timeout});
        end
        n_cmp++;
        if (o_eng_data !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", o_eng_data); end
        n_cmp++;
        if (o_grp_cnt !== '0) begin n_err++; $display("FAIL reset_grp: got %0d expected 0", o_grp_cnt); end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_basic();
        run(0, 0, RPG);
        n_cmp++;
        if (r_hung != 0) begin n_err++; $display("FAIL basic_end: run did not finish (hung=%0d, want 0)", r_hung); end
        n_cmp++;
        if (r_trig != NGRP * WPG) begin n_err++; $display("FAIL basic_trig: got %0d expected %0d", r_trig, NGRP * WPG); end
        n_cmp++;
        if (r_bad != 0) begin n_err++; $display("FAIL basic_data: got %0d bad words expected 0", r_bad); end
        n_cmp++;
        if (r_done != 1) begin n_err++; $display("FAIL basic_done: got %0d pulses expected 1", r_done); end
        n_cmp++;
        if (o_grp_cnt !== GC_W'(NGRP)) begin n_err++; $display("FAIL basic_grp: got %0d expected %0d", o_grp_cnt, NGRP); end
        n_cmp++;
        if (o_beat_err !== 1'b0) begin n_err++; $display("FAIL basic_beat_err: got %b expected 0", o_beat_err); end
        n_cmp++;
        if (r_gaps != LAST_DLY + 1) begin n_err++; $display("FAIL basic_gap: got %0d expected %0d", r_gaps, LAST_DLY + 1); end
`ifdef QR_SEQ_CHECK_EN
        n_cmp++;
        if (o_mis_cnt !== 16'd0 || o_gold_ufl !== 1'b0) begin
            n_err++; $display("FAIL basic_chk: got mis=%0d ufl=%b expected 0/0", o_mis_cnt, o_gold_ufl);
        end
`endif
    endtask

    task automatic test_src_bubbles();
        run(1, 0, RPG);
        n_cmp++;
        if (r_trig != NGRP * WPG || r_hung != 0) begin
            n_err++; $display("FAIL bubble_trig: got %0d (hung %0d) expected %0d", r_trig, r_hung, NGRP * WPG);
        end
        n_cmp++;
        if (r_hole != 0) begin n_err++; $display("FAIL bubble_holes: got %0d trig without word expected 0", r_hole); end
        n_cmp++;
        if (r_bad != 0) begin n_err++; $display("FAIL bubble_data: got %0d bad words expected 0", r_bad); end
        n_cmp++;
        if (r_done != 1) begin n_err++; $display("FAIL bubble_done: got %0d expected 1", r_done); end
    endtask

    task automatic test_random_src();
        run(2, 0, RPG);
        n_cmp++;
        if (r_trig != NGRP * WPG || r_bad != 0 || r_hole != 0) begin
            n_err++; $display("FAIL random_stream: got trig=%0d bad=%0d holes=%0d expected %0d/0/0", r_trig, r_bad, r_hole, NGRP * WPG);
        end
        n_cmp++;
        if (r_done != 1 || o_beat_err !== 1'b0) begin
            n_err++; $display("FAIL random_done: got done=%0d beat_err=%b expected 1/0", r_done, o_beat_err);
        end
    endtask

    task automatic test_last_with_last_word();
        run(0, 1, RPG);
        n_cmp++;
        if (r_gaps != 0) begin n_err++; $display("FAIL coincide_gap: got %0d idle trig cycles expected 0", r_gaps); end
        n_cmp++;
        if (r_trig != NGRP * WPG || r_bad != 0) begin
            n_err++; $display("FAIL coincide_data: got trig=%0d bad=%0d expected %0d/0", r_trig, r_bad, NGRP * WPG);
        end
        n_cmp++;
        if (r_done != 1 || o_grp_cnt !== GC_W'(NGRP) || o_beat_err !== 1'b0) begin
            n_err++; $display("FAIL coincide_close: got done=%0d grp=%0d beat_err=%b expected 1/%0d/0", r_done, o_grp_cnt, o_beat_err, NGRP);
        end
    endtask

    task automatic test_beat_err();
        run(0, 0, RPG - 1);
        n_cmp++;
        if (o_beat_err !== 1'b1) begin n_err++; $display("FAIL beat_err_set: got %b expected 1", o_beat_err); end
        n_cmp++;
        if (r_done != 1 || o_grp_cnt !== GC_W'(NGRP)) begin
            n_err++; $display("FAIL beat_err_run: got done=%0d grp=%0d expected 1/%0d", r_done, o_grp_cnt, NGRP);
        end
        repeat (5) @(negedge i_clk);
        n_cmp++;
        if (o_beat_err !== 1'b1) begin n_err++; $display("FAIL beat_err_sticky: got %b expected 1", o_beat_err); end
    endtask

    task automatic test_timeout();
        run(0, 2, 0);
        n_cmp++;
        if (o_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b expected 1", o_timeout); end
        n_cmp++;
        if (r_to_wait != TMO) begin n_err++; $display("FAIL timeout_cycles: got %0d expected %0d", r_to_wait, TMO); end
        n_cmp++;
        if (r_done != 0 || o_busy !== 1'b0 || r_hung != 0) begin
            n_err++; $display("FAIL timeout_idle: got done=%0d busy=%b hung=%0d expected 0/0/0", r_done, o_busy, r_hung);
        end
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        n_cmp++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
            n_err++; $display("FAIL timeout_clear: got timeout=%b busy=%b expected 0/1", o_timeout, o_busy);
        end
        i_rst = 1'b1;
        @(negedge i_clk); i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] rnd;
        int stray = 0;
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            i_src_vld  = 1'b1;
            rnd        = {$urandom(), $urandom()};
            i_src_data = rnd[DATA_W-1:0];
            @(negedge i_clk);
        end
        n_cmp++;
        if (o_eng_trig !== 1'b1 || o_busy !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: got trig=%b busy=%b expected 1/1", o_eng_trig, o_busy);
        end
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_src_rdy, o_eng_trig, o_busy, o_done} !== 4'b0 || o_eng_data !== '0 || o_grp_cnt !== '0) begin
            n_err++; $display("FAIL midrst_async: got flags=%b data=%h expected 0/0",
                              {o_src_rdy, o_eng_trig, o_busy, o_done}, o_eng_data);
        end
        @(posedge i_clk); #1;
        n_cmp++;
        if ({o_src_rdy, o_eng_trig, o_busy, o_done, o_beat_err, o_timeout} !== 6'b0) begin
            n_err++; $display("FAIL midrst_edge: got %b expected 000000",
                              {o_src_rdy, o_eng_trig, o_busy, o_done, o_beat_err, o_timeout});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (o_done || o_busy) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_err++; $display("FAIL midrst_after: got %0d busy/done cycles expected 0", stray); end
    endtask

`ifdef QR_SEQ_CHECK_EN
    task automatic test_checker();
        corrupt_beat = 7;
        ufl_beat     = 3;
        run(0, 0, RPG);
        corrupt_beat = -1;
        ufl_beat     = -1;
        n_cmp++;
        if (o_mis_cnt !== 16'd1) begin n_err++; $display("FAIL chk_mis: got %0d expected 1", o_mis_cnt); end
        n_cmp++;
        if (o_gold_ufl !== 1'b1) begin n_err++; $display("FAIL chk_ufl: got %b expected 1", o_gold_ufl); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_src_bubbles();
        test_random_src();
        test_last_with_last_word();
        test_beat_err();
        test_timeout();
`ifdef QR_SEQ_CHECK_EN
        test_checker();
`endif
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
